arbiter_rr8: RTL and testbench

ARBITER_RR8 -- requirements
Module: arbiter_rr8

---
 rtl/arb_pkg.sv | 12 +
 rtl/onehot_enc8.sv | 22 ++
 rtl/arbiter_rr8.sv | 120 ++++++++++++
 tb/tb_arbiter_rr8.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared defaults and FSM state encoding for the round-robin arbiter.
package arb_pkg;
    localparam int N_DEF        = 8;
    localparam int IDX_W_DEF    = 3;
    localparam int MAX_HOLD_DEF = 16;
    localparam int HOLD_W       = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;
endpackage

// File: rtl/onehot_enc8.sv
// One-hot to binary encoder; idx is 0 and valid is low for an all-zero input.
module onehot_enc8
    import arb_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);
    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (onehot[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
    end

    assign valid = |onehot;
endmodule

// File: rtl/arbiter_rr8.sv
// Round-robin arbiter with release on done / request drop and a forced
// release (timeout pulse) after MAX_HOLD granted cycles.
module arbiter_rr8
    import arb_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int IDX_W    = IDX_W_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             done,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout,
    output arb_state_e       dbg_state
);
    // Handshake: a requester holds req high until served; gnt is the
    // registered acknowledge and stays fixed until the owner pulses done,
    // drops its req, or the hold limit forces a release.
    localparam logic [N-1:0] GNT_ONE = {{(N-1){1'b0}}, 1'b1};

    arb_state_e        state_q, state_d;
    logic [N-1:0]      gnt_q, gnt_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              timeout_q, timeout_d;

    logic              win_found;
    logic [IDX_W-1:0]  win_idx;
    logic [IDX_W-1:0]  cand_idx;
    logic              rel_normal;
    logic              hold_max;

    // Search starts one past the last winner and wraps modulo N.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_idx  = '0;
        for (int k = 1; k <= N; k++) begin
            cand_idx = IDX_W'((int'(ptr_q) + k) % N);
            if (!win_found && req[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    assign rel_normal = done || !(|(gnt_q & req));
    assign hold_max   = (hold_q == HOLD_W'(MAX_HOLD - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            ptr_q     <= IDX_W'(N - 1);
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (win_found) state_d = ST_BUSY;
            ST_BUSY: if (rel_normal || hold_max) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // A normal release wins over the hold limit, so timeout only fires
    // when the owner neither finished nor withdrew.
    always_comb begin
        gnt_d     = gnt_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                gnt_d = '0;
                if (win_found) begin
                    gnt_d  = GNT_ONE << win_idx;
                    ptr_d  = win_idx;
                    hold_d = '0;
                end
            end
            ST_BUSY: begin
                if (rel_normal) begin
                    gnt_d  = '0;
                    hold_d = '0;
                end else if (hold_max) begin
                    gnt_d     = '0;
                    hold_d    = '0;
                    timeout_d = 1'b1;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: gnt_d = '0;
        endcase
    end

    onehot_enc8 #(.N(N), .IDX_W(IDX_W)) u_enc (
        .onehot (gnt_q),
        .idx    (gnt_idx),
        .valid  (gnt_valid)
    );

    assign gnt       = gnt_q;
    assign timeout   = timeout_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_arbiter_rr8.sv
// Bench for arbiter_rr8: directed scenarios plus randomized traffic checked
// against a cycle-level owner/hold model.
module tb_arbiter_rr8;
    import arb_pkg::*;

    localparam int MAX_HOLD = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic       done = 1'b0;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;
    arb_state_e dbg_state;

    int checks = 0;
    int failures = 0;

    // Reference model state: who owns the grant and for how many cycles.
    bit m_busy = 0;
    int m_owner = 0;
    int m_ptr = 7;
    int m_held = 0;
    bit m_tmo = 0;

    logic [7:0] e_gnt;
    logic [2:0] e_idx;
    logic       e_valid;
    logic       e_tmo;

    arbiter_rr8 #(.N(8), .IDX_W(3), .MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // Advance one clock, update the model from the inputs seen at the edge,
    // then settle 1 ns before the caller samples.
    task automatic step();
        int c;
        @(posedge clk);
        if (rst) begin
            m_busy = 0; m_owner = 0; m_ptr = 7; m_held = 0; m_tmo = 0;
        end else begin
            m_tmo = 0;
            if (!m_busy) begin
                if (req != 8'h00) begin
                    for (int k = 1; k <= 8; k++) begin
                        c = (m_ptr + k) % 8;
                        if (req[c]) begin
                            m_owner = c;
                            break;
                        end
                    end
                    m_ptr = m_owner; m_busy = 1; m_held = 1;
                end
            end else if (done || !req[m_owner]) begin
                m_busy = 0;
            end else if (m_held == MAX_HOLD) begin
                m_busy = 0; m_tmo = 1;
            end else begin
                m_held++;
            end
        end
        e_gnt   = m_busy ? (8'h01 << m_owner) : 8'h00;
        e_idx   = m_busy ? 3'(m_owner) : 3'd0;
        e_valid = m_busy;
        e_tmo   = m_tmo;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; done = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 8'($urandom_range(0, 255));
        done = 1'($urandom_range(0, 1));
        step();
        checks++;
        if ({gnt, gnt_idx, gnt_valid, timeout} !== 13'h0) begin
            failures++;
            $display("FAIL reset got gnt=%h idx=%0d v=%b to=%b exp all zero", gnt, gnt_idx, gnt_valid, timeout);
        end
        checks++;
        if (dbg_state !== ST_IDLE) begin
            failures++;
            $display("FAIL reset_state got %0d exp %0d", dbg_state, ST_IDLE);
        end
        rst = 1'b0; req = 8'h00; done = 1'b0;
        step();
    endtask

    task automatic test_single_grant();
        do_reset();
        req = 8'b0000_0001;
        step();
        checks++;
        if ({gnt, gnt_idx, gnt_valid} !== {8'h01, 3'd0, 1'b1}) begin
            failures++;
            $display("FAIL single_grant got gnt=%h idx=%0d v=%b exp gnt=01 idx=0 v=1", gnt, gnt_idx, gnt_valid);
        end
        done = 1'b1;
        step();
        done = 1'b0; req = 8'h00;
        checks++;
        if (gnt !== 8'h00 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL single_release got gnt=%h to=%b exp gnt=00 to=0", gnt, timeout);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            step();
            checks++;
            if (gnt_idx !== 3'(k % 8) || gnt_valid !== 1'b1 || gnt !== (8'h01 << (k % 8))) begin
                failures++;
                $display("FAIL rotation[%0d] got gnt=%h idx=%0d v=%b exp idx=%0d v=1", k, gnt, gnt_idx, gnt_valid, k % 8);
            end
            done = 1'b1;
            step();
            done = 1'b0;
            checks++;
            if (gnt !== 8'h00 || gnt_valid !== 1'b0) begin
                failures++;
                $display("FAIL idle_gap[%0d] got gnt=%h v=%b exp gnt=00 v=0", k, gnt, gnt_valid);
            end
        end
        req = 8'h00;
        step();
    endtask

    task automatic test_req_drop();
        do_reset();
        req = 8'b0000_1000;
        step();
        checks++;
        if (gnt_idx !== 3'd3 || gnt !== 8'h08) begin
            failures++;
            $display("FAIL drop_grant got gnt=%h idx=%0d exp gnt=08 idx=3", gnt, gnt_idx);
        end
        req = 8'b0000_0001;
        step();
        checks++;
        if (gnt !== 8'h00) begin
            failures++;
            $display("FAIL drop_release got gnt=%h exp 00", gnt);
        end
        req = 8'b0000_1001;
        step();
        checks++;
        if (gnt !== 8'h01 || gnt_idx !== 3'd0) begin
            failures++;
            $display("FAIL drop_wrap got gnt=%h idx=%0d exp gnt=01 idx=0", gnt, gnt_idx);
        end
        req = 8'h00;
        step();
    endtask

    task automatic test_timeout();
        int high;
        do_reset();
        req = 8'h04;
        step();
        high = (gnt !== 8'h00) ? 1 : 0;
        for (int c = 0; c < 40 && gnt !== 8'h00; c++) begin
            step();
            if (gnt !== 8'h00) high++;
        end
        checks++;
        if (high != MAX_HOLD || gnt !== 8'h00 || timeout !== 1'b1) begin
            failures++;
            $display("FAIL timeout got high_cycles=%0d gnt=%h to=%b exp high_cycles=%0d gnt=00 to=1", high, gnt, timeout, MAX_HOLD);
        end
        step();
        checks++;
        if (timeout !== 1'b0 || gnt !== 8'h04) begin
            failures++;
            $display("FAIL timeout_pulse got gnt=%h to=%b exp gnt=04 to=0", gnt, timeout);
        end
        req = 8'h00;
        step();
        step();
    endtask

    task automatic test_done_on_timeout();
        do_reset();
        req = 8'h20;
        step();
        repeat (MAX_HOLD - 1) step();
        checks++;
        if (gnt !== 8'h20) begin
            failures++;
            $display("FAIL hold_last got gnt=%h exp 20", gnt);
        end
        done = 1'b1;
        step();
        done = 1'b0;
        checks++;
        if (gnt !== 8'h00 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL done_wins got gnt=%h to=%b exp gnt=00 to=0", gnt, timeout);
        end
        req = 8'h00;
        step();
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        req = 8'h20;
        step();
        checks++;
        if (gnt !== 8'h20) begin
            failures++;
            $display("FAIL mid_grant got gnt=%h exp 20", gnt);
        end
        req = 8'hFF; rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (gnt !== 8'h00 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset got gnt=%h to=%b exp gnt=00 to=0", gnt, timeout);
        end
        step();
        checks++;
        if (gnt !== 8'h01 || gnt_idx !== 3'd0) begin
            failures++;
            $display("FAIL post_reset got gnt=%h idx=%0d exp gnt=01 idx=0", gnt, gnt_idx);
        end
        req = 8'h00;
        step();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0)
                req = 8'($urandom_range(0, 255) & $urandom_range(0, 255));
            if (i < 1500) done = ($urandom_range(0, 4) == 0);
            else          done = ($urandom_range(0, 39) == 0);
            rst = ($urandom_range(0, 199) == 0);
            step();
            checks++;
            if ({gnt, gnt_idx, gnt_valid, timeout} !== {e_gnt, e_idx, e_valid, e_tmo}) begin
                failures++;
                $display("FAIL random[%0d] got gnt=%h idx=%0d v=%b to=%b exp gnt=%h idx=%0d v=%b to=%b",
                         i, gnt, gnt_idx, gnt_valid, timeout, e_gnt, e_idx, e_valid, e_tmo);
            end
            checks++;
            if (dbg_state !== (m_busy ? ST_BUSY : ST_IDLE) || $countones(gnt) > 1) begin
                failures++;
                $display("FAIL random_state[%0d] got state=%0d gnt=%h exp state=%0d onehot", i, dbg_state, gnt, m_busy);
            end
        end
        rst = 1'b0; done = 1'b0; req = 8'h00;
        step();
    endtask

    initial begin
        test_reset();
        test_single_grant();
        test_back_to_back();
        test_req_drop();
        test_timeout();
        test_done_on_timeout();
        test_reset_mid_grant();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
